access_pattern_gen: RTL and testbench

Initiator-side driver for configurable_cache: generates address streams (sequential, LFSR-random, sector-reuse, strided), one address per clock. Consumes the cache's registered hit/miss response and keeps per-run hit/miss tallies. Replaces behavioural testbench loops, so cache experiments run as synthesizable hardware and sweep runs can be automated.

---
 rtl/apg_pkg.sv | 26 ++
 rtl/apg_lfsr32.sv | 38 +++
 rtl/access_pattern_gen.sv | 217 +++++++++++++++++++++
 tb/tb_access_pattern_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/apg_pkg.sv
// Shared definitions for access_pattern_gen.
//   - Mode codes for the address pattern selected at start.
//   - FSM state encoding.
//   - Galois LFSR taps and the single-step function used by apg_lfsr32.
package apg_pkg;

  localparam logic [1:0] MODE_SEQ    = 2'b00;
  localparam logic [1:0] MODE_RAND   = 2'b01;
  localparam logic [1:0] MODE_REUSE  = 2'b10;
  localparam logic [1:0] MODE_STRIDE = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StDrain = 2'b10,
    StDone  = 2'b11
  } apg_state_e;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // One step of a right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    lfsr_next = v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/apg_lfsr32.sv
// 32-bit Galois LFSR used for RAND-mode addresses.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset (loads the seed)
//   i_load         reload the seed
//   i_step         advance one step; with i_load, the step is taken from the seed
//   o_next_value   value the register holds after the next step (combinational)
module apg_lfsr32
  import apg_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_step,
  output logic [31:0] o_next_value
);

  // An all-zero state would lock the LFSR.
  localparam logic [31:0] SEED_FIX = (SEED == 32'h0) ? 32'h0000_0001 : SEED;

  logic [31:0] r_lfsr;
  logic [31:0] w_base;

  assign w_base       = i_load ? SEED_FIX : r_lfsr;
  assign o_next_value = lfsr_next(w_base);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr <= SEED_FIX;
    end else if (i_step) begin
      r_lfsr <= o_next_value;
    end else if (i_load) begin
      r_lfsr <= SEED_FIX;
    end
  end

endmodule

// File: rtl/access_pattern_gen.sv
// Address-stream generator driving configurable_cache: one access per clock in
// SEQ, RAND, REUSE or STRIDE pattern, tallying the cache's registered hit/miss
// responses per run.
// Optional feature macro: APG_RESP_CHECK_EN (response protocol error counter).
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_start                      run request, sampled only in IDLE
//   i_mode, i_stride, i_count    run configuration, latched at start
//   o_addr, o_addr_valid         access to the cache
//   i_cache_hit, i_cache_miss    registered cache response (one cycle after addr)
//   o_busy, o_done               run status; o_done is a one-cycle pulse
//   o_hit_count, o_miss_count    per-run response tallies
//   o_err_count                  protocol violations (0 unless APG_RESP_CHECK_EN)
module access_pattern_gen
  import apg_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH        = 32,
  parameter int unsigned LINE_SIZE         = 32,
  parameter int unsigned SECTOR_SIZE       = 8,
  parameter int unsigned REUSE_PERIOD      = 100,
  parameter int unsigned RANDOM_RANGE_BITS = 16,
  parameter logic [31:0] LFSR_SEED         = 32'h0000_0001
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [1:0]            i_mode,
  input  logic [15:0]           i_stride,
  input  logic [31:0]           i_count,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_addr_valid,
  input  logic                  i_cache_hit,
  input  logic                  i_cache_miss,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [31:0]           o_hit_count,
  output logic [31:0]           o_miss_count,
  output logic [31:0]           o_err_count
);

  localparam logic [ADDR_WIDTH-1:0] SECTOR_INC = ADDR_WIDTH'(SECTOR_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LINE_INC   = ADDR_WIDTH'(LINE_SIZE);
  localparam logic [ADDR_WIDTH-1:0] OFFS_MASK  = ADDR_WIDTH'(LINE_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] RAND_MASK  =
      {ADDR_WIDTH{1'b1}} >> (ADDR_WIDTH - RANDOM_RANGE_BITS);

  apg_state_e r_state, w_state_next;

  logic [1:0]            r_mode;
  logic [15:0]           r_stride;
  logic [31:0]           r_remain;      // accesses left after the one on o_addr
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_base;        // REUSE: current line base
  logic [ADDR_WIDTH-1:0] r_offset;      // REUSE: sector offset within the line
  logic [31:0]           r_period;      // REUSE: accesses issued on this base
  logic                  r_valid_d;
  logic [31:0]           r_hit_count;
  logic [31:0]           r_miss_count;

  logic                  w_accept;
  logic                  w_advance;
  logic                  w_period_wrap;
  logic [ADDR_WIDTH-1:0] w_base_next;
  logic [ADDR_WIDTH-1:0] w_offset_next;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [ADDR_WIDTH-1:0] w_rand_addr;
  logic [31:0]           w_lfsr_next;
  logic                  w_lfsr_step;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    o_addr_valid = 1'b0;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_accept     = 1'b1;
          w_state_next = (i_count == 32'd0) ? StDone : StRun;
        end
      end
      StRun: begin
        o_addr_valid = 1'b1;
        if (r_remain == 32'd0) begin
          w_state_next = StDrain;
        end
      end
      StDrain: w_state_next = StDone;
      StDone: begin
        o_done       = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Moving on to the next access within the same run.
  assign w_advance = (r_state == StRun) && (r_remain != 32'd0);

  // ---------------------------------------------------------------------------
  // Address generation
  // ---------------------------------------------------------------------------
  assign w_lfsr_step = (w_accept && (i_mode == MODE_RAND)) ||
                       (w_advance && (r_mode == MODE_RAND));

  apg_lfsr32 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_load       (w_accept),
    .i_step       (w_lfsr_step),
    .o_next_value (w_lfsr_next)
  );

  assign w_rand_addr   = ADDR_WIDTH'(w_lfsr_next) & RAND_MASK;
  assign w_period_wrap = (r_period == REUSE_PERIOD - 1);
  assign w_base_next   = w_period_wrap ? (r_base + LINE_INC) : r_base;
  // Sector index cycles independently of base moves; line size is a power of 2.
  assign w_offset_next = (r_offset + SECTOR_INC) & OFFS_MASK;

  always_comb begin
    w_addr_next = r_addr + SECTOR_INC;
    unique case (r_mode)
      MODE_SEQ:    w_addr_next = r_addr + SECTOR_INC;
      MODE_RAND:   w_addr_next = w_rand_addr;
      MODE_REUSE:  w_addr_next = w_base_next + w_offset_next;
      MODE_STRIDE: w_addr_next = r_addr + ADDR_WIDTH'(r_stride);
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and response tallies
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode       <= MODE_SEQ;
      r_stride     <= '0;
      r_remain     <= '0;
      r_addr       <= '0;
      r_base       <= '0;
      r_offset     <= '0;
      r_period     <= '0;
      r_valid_d    <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_valid_d <= o_addr_valid;
      if (w_accept) begin
        r_mode       <= i_mode;
        r_stride     <= i_stride;
        r_remain     <= i_count - 32'd1;
        r_base       <= '0;
        r_offset     <= '0;
        r_period     <= '0;
        r_hit_count  <= '0;
        r_miss_count <= '0;
        r_addr       <= (i_mode == MODE_RAND) ? w_rand_addr : '0;
      end else begin
        if (w_advance) begin
          r_remain <= r_remain - 32'd1;
          r_addr   <= w_addr_next;
          r_base   <= w_base_next;
          r_offset <= w_offset_next;
          r_period <= w_period_wrap ? 32'd0 : r_period + 32'd1;
        end
        if (r_valid_d && i_cache_hit) begin
          r_hit_count <= r_hit_count + 32'd1;
        end
        if (r_valid_d && i_cache_miss) begin
          r_miss_count <= r_miss_count + 32'd1;
        end
      end
    end
  end

  assign o_addr       = r_addr;
  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;

`ifdef APG_RESP_CHECK_EN
  logic [31:0] r_err_count;
  logic        w_resp_err;

  // A live response must be exactly one of hit/miss; an idle slot must be silent.
  assign w_resp_err = r_valid_d ? (i_cache_hit == i_cache_miss)
                                : (i_cache_hit | i_cache_miss);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err_count <= '0;
    end else if (w_accept) begin
      r_err_count <= '0;
    end else if (w_resp_err && (r_err_count != 32'hFFFF_FFFF)) begin
      r_err_count <= r_err_count + 32'd1;
    end
  end

  assign o_err_count = r_err_count;
`else
  assign o_err_count = 32'd0;
`endif

endmodule

// File: tb/tb_access_pattern_gen.sv
// Directed self-checking bench for access_pattern_gen (default parameters).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_access_pattern_gen;
  import apg_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] stride;
  logic [31:0] count;
  logic [31:0] addr;
  logic        addr_valid;
  logic        hit;
  logic        miss;
  logic        busy;
  logic        done;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic [31:0] err_count;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  int d0;

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_seen++;

  access_pattern_gen u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_mode       (mode),
    .i_stride     (stride),
    .i_count      (count),
    .o_addr       (addr),
    .o_addr_valid (addr_valid),
    .i_cache_hit  (hit),
    .i_cache_miss (miss),
    .o_busy       (busy),
    .o_done       (done),
    .o_hit_count  (hit_count),
    .o_miss_count (miss_count),
    .o_err_count  (err_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resp(input logic h, input logic m);
    hit  = h;
    miss = m;
  endtask

  // Returns 1 time unit after the accepting edge E0.
  task automatic launch(input logic [1:0] md, input logic [15:0] st, input logic [31:0] cnt);
    mode   = md;
    stride = st;
    count  = cnt;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = MODE_SEQ; stride = '0; count = '0;
    resp(1'b0, 1'b0);
    tick();
    tick();
    check_eq("rst_addr", addr, 0);
    check_eq("rst_valid", addr_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_hits", hit_count, 0);
    check_eq("rst_misses", miss_count, 0);
    check_eq("rst_err", err_count, 0);
    rst = 1'b0;
    tick();

    // SEQ, count=4, responses miss,miss,hit,hit
    d0 = done_seen;
    launch(MODE_SEQ, 16'h0, 32'd4);
    check_eq("seq_a0", addr, 0);
    check_eq("seq_v0", addr_valid, 1);
    check_eq("seq_busy", busy, 1);
    tick(); check_eq("seq_a1", addr, 8);  resp(1'b0, 1'b1);
    tick(); check_eq("seq_a2", addr, 16); resp(1'b0, 1'b1);
    tick(); check_eq("seq_a3", addr, 24); resp(1'b1, 1'b0);
    tick();
    check_eq("seq_drain_valid", addr_valid, 0);
    check_eq("seq_drain_done", done, 0);
    resp(1'b1, 1'b0);
    tick();
    check_eq("seq_done_e5", done, 1);
    check_eq("seq_hits", hit_count, 2);
    check_eq("seq_misses", miss_count, 2);
    check_eq("seq_err", err_count, 0);
    resp(1'b0, 1'b0);
    tick();
    check_eq("seq_done_low", done, 0);
    check_eq("seq_idle", busy, 0);
    check_eq("seq_hits_hold", hit_count, 2);
    check_eq("seq_one_done", done_seen - d0, 1);

    // RAND, seed 1, 16-bit mask: 0x8020_0003 -> 0x3, 0xC030_0002 -> 0x2
    launch(MODE_RAND, 16'h0, 32'd2);
    check_eq("rand_a0", addr, 32'h3);
    tick(); check_eq("rand_a1", addr, 32'h2); resp(1'b1, 1'b0);
    tick(); check_eq("rand_drain", addr_valid, 0); resp(1'b0, 1'b1);
    tick();
    check_eq("rand_done", done, 1);
    check_eq("rand_hits", hit_count, 1);
    check_eq("rand_misses", miss_count, 1);
    resp(1'b0, 1'b0);
    tick();

    // REUSE, count=101, all hits
    launch(MODE_REUSE, 16'h0, 32'd101);
    for (int k = 0; k < 101; k++) begin
      case (k)
        0:   check_eq("reuse_k0", addr, 0);
        1:   check_eq("reuse_k1", addr, 8);
        2:   check_eq("reuse_k2", addr, 16);
        3:   check_eq("reuse_k3", addr, 24);
        99:  check_eq("reuse_k99", addr, 24);
        100: check_eq("reuse_k100", addr, 32);
        default: ;
      endcase
      tick();
      resp(1'b1, 1'b0);
    end
    check_eq("reuse_drain", addr_valid, 0);
    tick();
    check_eq("reuse_done", done, 1);
    check_eq("reuse_hits", hit_count, 101);
    check_eq("reuse_misses", miss_count, 0);
    resp(1'b0, 1'b0);
    tick();

    // STRIDE 0x1000, count=3, start re-pulsed (with other settings) during RUN
    d0 = done_seen;
    launch(MODE_STRIDE, 16'h1000, 32'd3);
    check_eq("stride_a0", addr, 0);
    mode = MODE_SEQ; count = 32'd7; start = 1'b1;
    tick(); start = 1'b0;
    check_eq("stride_a1", addr, 32'h1000); resp(1'b0, 1'b1);
    tick(); check_eq("stride_a2", addr, 32'h2000); resp(1'b0, 1'b1);
    tick(); check_eq("stride_drain", addr_valid, 0); resp(1'b0, 1'b1);
    tick();
    check_eq("stride_done", done, 1);
    check_eq("stride_misses", miss_count, 3);
    check_eq("stride_hits", hit_count, 0);
    resp(1'b0, 1'b0);
    tick();
    check_eq("stride_idle", busy, 0);
    tick();
    tick();
    check_eq("stride_no_rerun", addr_valid, 0);
    check_eq("stride_one_done", done_seen - d0, 1);

    // count=0: straight to DONE, counts cleared
    d0 = done_seen;
    launch(MODE_SEQ, 16'h0, 32'd0);
    check_eq("zero_done", done, 1);
    check_eq("zero_valid", addr_valid, 0);
    check_eq("zero_misses", miss_count, 0);
    check_eq("zero_hits", hit_count, 0);
    tick();
    check_eq("zero_done_low", done, 0);
    check_eq("zero_idle", busy, 0);
    tick();
    check_eq("zero_one_done", done_seen - d0, 1);

    // Reset mid-run at k=5
    d0 = done_seen;
    launch(MODE_SEQ, 16'h0, 32'd10);
    for (int k = 0; k < 5; k++) begin
      tick();
      resp(1'b1, 1'b0);
    end
    check_eq("abort_a5", addr, 40);
    check_eq("abort_hits_pre", hit_count, 4);
    rst = 1'b1;
    tick();
    resp(1'b0, 1'b0);
    check_eq("abort_valid", addr_valid, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_addr", addr, 0);
    check_eq("abort_hits", hit_count, 0);
    check_eq("abort_misses", miss_count, 0);
    rst = 1'b0;
    tick();
    tick();
    tick();
    check_eq("abort_stay_idle", busy, 0);
    check_eq("abort_no_done", done_seen - d0, 0);

    // Illegal response: hit and miss both high
    launch(MODE_SEQ, 16'h0, 32'd1);
    check_eq("err_a0", addr, 0);
    tick();
    resp(1'b1, 1'b1);
    tick();
    resp(1'b0, 1'b0);
    check_eq("err_done", done, 1);
    check_eq("err_hits", hit_count, 1);
    check_eq("err_misses", miss_count, 1);
`ifdef APG_RESP_CHECK_EN
    check_eq("err_count", err_count, 1);
`else
    check_eq("err_count", err_count, 0);
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
